// File: rtl/iter_compare.sv
// Iterative magnitude comparator: walks the operands CHUNK bits at a time, MSB chunk first.
// Optional macro ITER_COMPARE_SIGNED_EN adds a signed_mode input for two's-complement ordering.
module iter_compare #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ITER_COMPARE_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             found, pend_lt;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic             slice_ne, slice_lt, last_slice, accept;
`ifdef ITER_COMPARE_SIGNED_EN
  logic             sm_q;
`endif

  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == '0);

  // Flipping both sign bits turns an unsigned compare of the top slice into a signed one.
  always_comb begin
    slice_a = a_q[int'(idx)*CHUNK +: CHUNK];
    slice_b = b_q[int'(idx)*CHUNK +: CHUNK];
`ifdef ITER_COMPARE_SIGNED_EN
    if (sm_q && idx == IW'(NCHUNK-1)) begin
      slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
      slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
    end
`endif
    slice_ne = (slice_a != slice_b);
    slice_lt = (slice_a < slice_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if ((EARLY_EXIT != 0 && slice_ne) || last_slice) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    out_valid = (state == DONE);
  end

  // found/pend_lt remember the first differing slice so later slices cannot override it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      found   <= 1'b0;
      pend_lt <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      gt      <= 1'b0;
`ifdef ITER_COMPARE_SIGNED_EN
      sm_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IW'(NCHUNK-1);
            found <= 1'b0;
`ifdef ITER_COMPARE_SIGNED_EN
            sm_q  <= signed_mode;
`endif
          end
        end
        RUN: begin
          if (!found && slice_ne) begin
            found   <= 1'b1;
            pend_lt <= slice_lt;
          end
          if (state_next == DONE) begin
            if (found) begin
              lt <= pend_lt;
              gt <= ~pend_lt;
              eq <= 1'b0;
            end else if (slice_ne) begin
              lt <= slice_lt;
              gt <= ~slice_lt;
              eq <= 1'b0;
            end else begin
              lt <= 1'b0;
              gt <= 1'b0;
              eq <= 1'b1;
            end
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            eq <= 1'b0;
            lt <= 1'b0;
            gt <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_compare.sv
// Directed bench for iter_compare: default config, EARLY_EXIT=0, and CHUNK=WIDTH instances.
// Signed-mode vectors run only when ITER_COMPARE_SIGNED_EN is defined.
module tb_iter_compare;

  logic        clk;
  logic        rst_n;
  logic        iv[3], orr[3], sm[3];
  logic [31:0] av[3], bv[3];
  logic        ir[3], ov[3], e[3], l[3], g[3];

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  iter_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
`ifdef ITER_COMPARE_SIGNED_EN
    .signed_mode(sm[0]),
`endif
    .out_valid(ov[0]), .out_ready(orr[0]), .eq(e[0]), .lt(l[0]), .gt(g[0]));

  iter_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
`ifdef ITER_COMPARE_SIGNED_EN
    .signed_mode(sm[1]),
`endif
    .out_valid(ov[1]), .out_ready(orr[1]), .eq(e[1]), .lt(l[1]), .gt(g[1]));

  iter_compare #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
`ifdef ITER_COMPARE_SIGNED_EN
    .signed_mode(sm[2]),
`endif
    .out_valid(ov[2]), .out_ready(orr[2]), .eq(e[2]), .lt(l[2]), .gt(g[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one operand pair, scrambles the inputs after acceptance, and
  // returns the number of edges from the accept edge until out_valid is seen.
  task automatic applyStimulus(input int id, input logic [31:0] x, input logic [31:0] y,
                               input logic s, output int latency);
    checkOutput("ready_before_accept", {31'd0, ir[id]}, 32'd1);
    iv[id] = 1'b1;
    av[id] = x;
    bv[id] = y;
    sm[id] = s;
    @(posedge clk);
    #1;
    iv[id] = 1'b0;
    av[id] = ~x;
    bv[id] = x;
    sm[id] = ~s;
    latency = 1;
    while (!ov[id] && latency < 50) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic checkResult(input string tag, input int id, input int latency, input int exp_lat,
                             input logic xe, input logic xl, input logic xg);
    checkOutput({tag, "_lat"}, latency, exp_lat);
    checkOutput({tag, "_valid"}, {31'd0, ov[id]}, 32'd1);
    checkOutput({tag, "_eq"}, {31'd0, e[id]}, {31'd0, xe});
    checkOutput({tag, "_lt"}, {31'd0, l[id]}, {31'd0, xl});
    checkOutput({tag, "_gt"}, {31'd0, g[id]}, {31'd0, xg});
    orr[id] = 1'b1;
    @(posedge clk);
    #1;
    orr[id] = 1'b0;
    checkOutput({tag, "_pop_valid"}, {31'd0, ov[id]}, 32'd0);
    checkOutput({tag, "_pop_flags"}, {29'd0, e[id], l[id], g[id]}, 32'd0);
    checkOutput({tag, "_pop_ready"}, {31'd0, ir[id]}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b0; sm[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    #3;
    checkOutput("reset_ready", {31'd0, ir[0]}, 32'd0);
    checkOutput("reset_valid", {31'd0, ov[0]}, 32'd0);
    checkOutput("reset_flags", {29'd0, e[0], l[0], g[0]}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_ready", {31'd0, ir[0]}, 32'd1);

    applyStimulus(0, 32'h12345678, 32'h12345678, 1'b0, lat);
    checkResult("equal", 0, lat, 5, 1'b1, 1'b0, 1'b0);

    applyStimulus(0, 32'h80000000, 32'h7FFFFFFF, 1'b0, lat);
    checkResult("msb_unsigned", 0, lat, 2, 1'b0, 1'b0, 1'b1);

    applyStimulus(0, 32'h12345600, 32'h12345601, 1'b0, lat);
    checkResult("lsb_lt", 0, lat, 5, 1'b0, 1'b1, 1'b0);

    applyStimulus(0, 32'h12FF0000, 32'h12000000, 1'b0, lat);
    checkResult("chunk2_gt", 0, lat, 3, 1'b0, 1'b0, 1'b1);

`ifdef ITER_COMPARE_SIGNED_EN
    applyStimulus(0, 32'h80000000, 32'h7FFFFFFF, 1'b1, lat);
    checkResult("msb_signed", 0, lat, 2, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, lat);
    checkResult("neg_signed", 0, lat, 5, 1'b0, 1'b0, 1'b1);
`endif

    // Hold the result under backpressure and offer a second pair that must be ignored.
    applyStimulus(0, 32'h00000010, 32'h00000020, 1'b0, lat);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        iv[0] = 1'b1; av[0] = 32'h0; bv[0] = 32'h0;
      end
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      checkOutput("stall_valid", {31'd0, ov[0]}, 32'd1);
      checkOutput("stall_flags", {29'd0, e[0], l[0], g[0]}, 32'b010);
      checkOutput("stall_ready", {31'd0, ir[0]}, 32'd0);
    end
    checkResult("stall_release", 0, lat, 5, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("no_ghost_accept", {31'd0, ov[0]}, 32'd0);

    // Reset during the second RUN cycle abandons the transaction.
    iv[0] = 1'b1; av[0] = 32'h12345678; bv[0] = 32'h12345678;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_ready", {31'd0, ir[0]}, 32'd0);
    checkOutput("midrun_reset_valid", {31'd0, ov[0]}, 32'd0);
    checkOutput("midrun_reset_flags", {29'd0, e[0], l[0], g[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ready", {31'd0, ir[0]}, 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (ov[0]) seen++;
    end
    checkOutput("post_reset_no_result", seen, 0);
    applyStimulus(0, 32'd5, 32'd9, 1'b0, lat);
    checkResult("after_reset_lt", 0, lat, 5, 1'b0, 1'b1, 1'b0);

    applyStimulus(1, 32'h01000000, 32'h00000000, 1'b0, lat);
    checkResult("full_run_gt", 1, lat, 5, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 32'h80000000, 32'h7FFFFFFF, 1'b0, lat);
    checkResult("full_run_first_wins", 1, lat, 5, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 32'hABCDEF01, 32'hABCDEF01, 1'b0, lat);
    checkResult("full_run_eq", 1, lat, 5, 1'b1, 1'b0, 1'b0);

    applyStimulus(2, 32'd3, 32'd3, 1'b0, lat);
    checkResult("single_chunk_eq", 2, lat, 2, 1'b1, 1'b0, 1'b0);
    applyStimulus(2, 32'd2, 32'hFFFFFFFF, 1'b0, lat);
    checkResult("single_chunk_lt", 2, lat, 2, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_compare.md
ITER_COMPARE -- requirements
Module: iter_compare

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits compared per cycle; WIDTH SHALL be a multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 Parameter EARLY_EXIT, default 1: 1 = finish at the first differing chunk; 0 = always run NCHUNK cycles.
REQ-004 clk  input  1  sole clock; rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operands a, b offered.
REQ-007 in_ready  output  1  block accepts operands.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  eq/lt/gt hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 eq, lt, gt  output  1 each  registered result flags: A==B, A<B, A>B.

Function
REQ-013 FSM states: IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE with rst_n high.
REQ-014 IDLE: on in_valid&&in_ready at an edge, capture a, b (and signed_mode if present), set chunk index to NCHUNK-1 (MSB chunk), go to RUN.
REQ-015 RUN: each cycle compare the indexed CHUNK-bit slice, unsigned, MSB chunk first.
REQ-016 RUN with EARLY_EXIT=1: slice differs -> latch lt/gt from that slice, go to DONE; slices equal and index 0 -> latch eq, go to DONE; otherwise decrement index.
REQ-017 RUN with EARLY_EXIT=0: latch the result of the first differing slice only; later slices SHALL NOT alter it; go to DONE after index 0 (exactly NCHUNK RUN cycles).
REQ-018 Latency: out_valid rises the cycle after the final RUN cycle, i.e. k+1 cycles after the accept edge, where k = 1-based position of the first differing chunk from the MSB (NCHUNK if equal or EARLY_EXIT=0).
REQ-019 DONE: out_valid=1, exactly one of eq/lt/gt is 1, all held stable until out_valid&&out_ready at an edge, then return to IDLE.
REQ-020 eq/lt/gt SHALL be 0 outside DONE.
REQ-021 in_valid while in_ready=0 SHALL be ignored; input changes during RUN/DONE SHALL not affect the result.
REQ-022 CHUNK=WIDTH SHALL be legal: one RUN cycle per comparison.
REQ-023 The block SHALL hold one transaction at a time; no acceptance overlaps DONE.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, index 0, captured operands 0, out_valid=0, eq=lt=gt=0, in_ready=0.
REQ-025 Reset mid-RUN or mid-DONE SHALL abandon the transaction with no result; in_ready=1 in the first cycle after rst_n rises.

Configuration
REQ-026 Macro ITER_COMPARE_SIGNED_EN defined: add input signed_mode (1 bit, captured with operands); when 1, the MSB slice comparison inverts both operand sign bits (two's-complement order); lower slices stay unsigned.
REQ-027 Macro undefined: no signed_mode port; comparison always unsigned; all other behaviour identical.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-028 a=b=0x12345678 -> 4 RUN cycles, out_valid 5 cycles after accept, eq=1, lt=gt=0.
REQ-029 a=0x80000000, b=0x7FFFFFFF, unsigned -> gt=1, out_valid 2 cycles after accept; with ITER_COMPARE_SIGNED_EN and signed_mode=1 -> lt=1.
REQ-030 a=0x12345600, b=0x12345601 -> lt=1 after 4 RUN cycles; EARLY_EXIT=0 with a=0x01000000, b=0 -> gt=1, still 4 RUN cycles.
REQ-031 Backpressure: out_ready low 3 cycles in DONE -> out_valid and flags stable; in_valid pulsed then is not accepted; out_ready high -> IDLE next cycle.
REQ-032 rst_n low during RUN cycle 2 -> all outputs 0 immediately, no out_valid after release; next transaction a=5, b=9 -> lt=1.
REQ-033 CHUNK=32, a=3, b=3 -> eq=1, out_valid 2 cycles after accept.
